// File: rtl/toggle_handshake_rx_pkg.sv
// Shared constants and width helpers for the toggle-handshake receiver.
package toggle_handshake_rx_pkg;

  // Fewest synchroniser stages that still give a settled request bit.
  localparam int MIN_SYNC = 2;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_width(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

  // Width of an occupancy count that must reach DEPTH itself.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/toggle_handshake_rx_if.sv
// Bundle of the sender-facing toggle handshake and the consumer ready/valid port.
interface toggle_handshake_rx_if
  import toggle_handshake_rx_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DW    = 8,
  parameter int DEPTH = 4
);

  localparam int CW = ch_width(NCH);
  localparam int LW = level_width(DEPTH);

  logic [NCH-1:0]    req_tgl;
  logic [NCH*DW-1:0] data_in;
  logic [NCH-1:0]    ack_tgl;
  logic [NCH-1:0]    pending;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_ch;
  logic [LW-1:0]     level;

  // Receiver side.
  modport slave (
    input  req_tgl, data_in, out_ready,
    output ack_tgl, pending, out_valid, out_data, out_ch, level
  );

  // Senders plus consumer side.
  modport master (
    output req_tgl, data_in, out_ready,
    input  ack_tgl, pending, out_valid, out_data, out_ch, level
  );

endinterface

// File: rtl/toggle_handshake_rx_sync_fifo.sv
// First-word-fall-through FIFO holding {channel, data} entries.
module toggle_handshake_rx_sync_fifo
  import toggle_handshake_rx_pkg::*;
#(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en_i,
  input  logic [W-1:0]                  wr_data_i,
  input  logic                          rd_ready_i,
  output logic                          can_wr_o,
  output logic                          rd_valid_o,
  output logic [W-1:0]                  rd_data_o,
  output logic [level_width(DEPTH)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          rd_fire;
  logic          wr_fire;

  assign rd_valid_o = (level_q != '0);
  assign rd_fire    = rd_valid_o && rd_ready_i;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign can_wr_o   = (level_q < LW'(DEPTH)) || rd_fire;
  assign wr_fire    = wr_en_i && can_wr_o;
  // Head is zero while empty so stale storage never shows on the outputs.
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
  assign level_o    = level_q;

  // Pointer and occupancy next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_fire, rd_fire})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array, left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/toggle_handshake_rx.sv
// Multi-channel two-phase toggle receiver: synchronise requests, arbitrate
// round-robin, buffer words in a FIFO and return per-channel ack toggles.
module toggle_handshake_rx
  import toggle_handshake_rx_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int DW    = 8,
  parameter int SYNC  = 2,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  toggle_handshake_rx_if.slave  bus
);

  localparam int CW     = ch_width(NCH);
  localparam int LW     = level_width(DEPTH);
  localparam int SYNC_N = (SYNC < MIN_SYNC) ? MIN_SYNC : SYNC;
  localparam int FW     = CW + DW;

  logic [NCH-1:0] req_s;
  logic [NCH-1:0] ack_q, ack_d;
  logic [NCH-1:0] pend;
  logic [CW-1:0]  rr_ptr_q, rr_ptr_d;
  logic           grant_found;
  logic           grant;
  int             grant_sel;
  int             idx;
  logic [DW-1:0]  grant_data;
  logic           can_wr;
  logic           fifo_valid;
  logic [FW-1:0]  fifo_rdata;
  logic [LW-1:0]  fifo_level;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_sync
      logic [SYNC_N-1:0] sync_q;
      // Shift the asynchronous request toggle through the synchroniser chain.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_N-2:0], bus.req_tgl[gi]};
      end
      assign req_s[gi] = sync_q[SYNC_N-1];
    end
  endgenerate

  // Both operands are flops, so pending cannot glitch.
  assign pend        = req_s ^ ack_q;
  assign bus.pending = pend;
  assign bus.ack_tgl = ack_q;

  // Round-robin search from rr_ptr for the first pending channel.
  always_comb begin
    grant_found = 1'b0;
    grant_sel   = 0;
    idx         = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!grant_found && pend[idx]) begin
        grant_found = 1'b1;
        grant_sel   = idx;
      end
    end
    grant_data = bus.data_in[grant_sel*DW +: DW];
  end

  assign grant = grant_found && can_wr;

  // Ack flip and pointer advance for the granted channel.
  always_comb begin
    ack_d    = ack_q;
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      ack_d[grant_sel] = ~ack_q[grant_sel];
      if (grant_sel == NCH - 1) rr_ptr_d = '0;
      else                      rr_ptr_d = CW'(grant_sel + 1);
    end
  end

  // Ack toggles and arbitration pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      ack_q    <= ack_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  toggle_handshake_rx_sync_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (grant),
    .wr_data_i  ({CW'(grant_sel), grant_data}),
    .rd_ready_i (bus.out_ready),
    .can_wr_o   (can_wr),
    .rd_valid_o (fifo_valid),
    .rd_data_o  (fifo_rdata),
    .level_o    (fifo_level)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_rdata[DW-1:0];
  assign bus.out_ch    = fifo_rdata[FW-1:DW];
  assign bus.level     = fifo_level;

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Self-checking bench for toggle_handshake_rx (NCH=2, DW=8, SYNC=2, DEPTH=4).
module tb_toggle_handshake_rx;

  localparam int NCH   = 2;
  localparam int DW    = 8;
  localparam int SYNC  = 2;
  localparam int DEPTH = 4;

  typedef struct {
    int         ch;
    logic [7:0] data;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  entry_t model_q[$];

  always #5 clk = ~clk;

  toggle_handshake_rx_if #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) bus ();

  toggle_handshake_rx #(
    .NCH(NCH), .DW(DW), .SYNC(SYNC), .DEPTH(DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus helpers (drive only).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_tgl   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input int ch, input logic [7:0] d);
    bus.data_in[ch*DW +: DW] = d;
    bus.req_tgl[ch] = ~bus.req_tgl[ch];
    $display("send ch=%0d data=%02h", ch, d);
  endtask

  task automatic wait_ack(input int ch, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.ack_tgl[ch] == bus.req_tgl[ch]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_tgl = '0;
    bus.data_in = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ack_tgl !== 2'b00 || bus.out_valid !== 1'b0 || bus.level !== 3'd0 ||
        bus.out_data !== 8'h00 || bus.out_ch !== 1'b0 || bus.pending !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: ack=%b valid=%b level=%0d data=%h ch=%0d pend=%b, want all 0",
               bus.ack_tgl, bus.out_valid, bus.level, bus.out_data, bus.out_ch, bus.pending);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.pending !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: valid=%b pend=%b, want 0/00", bus.out_valid, bus.pending);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.data_in[7:0] = 8'hA5;
    bus.req_tgl[0] = 1'b1;
    $display("send ch=0 data=a5");
    @(negedge clk);  // after edge 1
    checks++;
    if (bus.ack_tgl[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_ack_e1: ack0=%b want 0", bus.ack_tgl[0]);
    end
    @(negedge clk);  // after edge 2
    checks++;
    if (bus.pending[0] !== 1'b1 || bus.out_valid !== 1'b0 || bus.ack_tgl[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_e2: pend0=%b valid=%b ack0=%b want 1/0/0",
               bus.pending[0], bus.out_valid, bus.ack_tgl[0]);
    end
    @(negedge clk);  // after edge 3
    checks++;
    if (bus.ack_tgl[0] !== 1'b1 || bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 ||
        bus.out_ch !== 1'b0 || bus.level !== 3'd1 || bus.pending[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_e3: ack0=%b valid=%b data=%h ch=%0d level=%0d pend0=%b want 1/1/a5/0/1/0",
               bus.ack_tgl[0], bus.out_valid, bus.out_data, bus.out_ch, bus.level, bus.pending[0]);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.level !== 3'd0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: level=%0d valid=%b want 0/0", bus.level, bus.out_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] d0, d1;
    do_reset();
    bus.out_ready = 1'b1;
    for (int round = 0; round < 2; round++) begin
      d0 = (round == 0) ? 8'h11 : 8'($urandom_range(0, 255));
      d1 = (round == 0) ? 8'h22 : 8'($urandom_range(0, 255));
      send(0, d0);
      send(1, d1);
      repeat (3) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== 1'b0 || bus.out_data !== d0) begin
        errors++;
        $display("FAIL simul_first r%0d: valid=%b ch=%0d data=%h want 1/0/%h",
                 round, bus.out_valid, bus.out_ch, bus.out_data, d0);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== 1'b1 || bus.out_data !== d1) begin
        errors++;
        $display("FAIL simul_second r%0d: valid=%b ch=%0d data=%h want 1/1/%h",
                 round, bus.out_valid, bus.out_ch, bus.out_data, d1);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.ack_tgl !== bus.req_tgl) begin
        errors++;
        $display("FAIL simul_done r%0d: valid=%b ack=%b req=%b want 0, ack==req",
                 round, bus.out_valid, bus.ack_tgl, bus.req_tgl);
      end
    end
    // Pointer is back at 0; a lone ch1 request must still be granted at once.
    d1 = 8'($urandom_range(0, 255));
    send(1, d1);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 1'b1 || bus.out_data !== d1) begin
      errors++;
      $display("FAIL simul_lone_ch1: valid=%b ch=%0d data=%h want 1/1/%h",
               bus.out_valid, bus.out_ch, bus.out_data, d1);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic [7:0] vals [5];
    bit ok;
    logic ack0_before;
    do_reset();
    for (int i = 0; i < 5; i++) vals[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) begin
      send(i % 2, vals[i]);
      wait_ack(i % 2, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL bp_ack%0d: ack timeout, want ack within 20 cycles", i);
      end
    end
    checks++;
    if (bus.level !== 3'd4) begin
      errors++;
      $display("FAIL bp_full: level=%0d want 4", bus.level);
    end
    ack0_before = bus.ack_tgl[0];
    send(0, vals[4]);
    repeat (SYNC + 3) @(negedge clk);
    checks++;
    if (bus.pending[0] !== 1'b1 || bus.ack_tgl[0] !== ack0_before || bus.level !== 3'd4) begin
      errors++;
      $display("FAIL bp_stall: pend0=%b ack0=%b level=%0d want 1/%b/4",
               bus.pending[0], bus.ack_tgl[0], bus.level, ack0_before);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.level !== 3'd4 || bus.ack_tgl[0] !== ~ack0_before || bus.pending[0] !== 1'b0 ||
        bus.out_ch !== 1'b1 || bus.out_data !== vals[1]) begin
      errors++;
      $display("FAIL bp_rw_same_edge: level=%0d ack0=%b pend0=%b ch=%0d data=%h want 4/%b/0/1/%h",
               bus.level, bus.ack_tgl[0], bus.pending[0], bus.out_ch, bus.out_data,
               ~ack0_before, vals[1]);
    end
    bus.out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== 1'(i % 2) || bus.out_data !== vals[i]) begin
        errors++;
        $display("FAIL bp_drain%0d: valid=%b ch=%0d data=%h want 1/%0d/%h",
                 i, bus.out_valid, bus.out_ch, bus.out_data, i % 2, vals[i]);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== 3'd0) begin
      errors++;
      $display("FAIL bp_empty: valid=%b level=%0d want 0/0", bus.out_valid, bus.level);
    end
  endtask

  task automatic test_fairness();
    logic [NCH-1:0] prev_ack, chg;
    int last, grants, g;
    bit drained;
    do_reset();
    bus.out_ready = 1'b1;
    prev_ack = bus.ack_tgl;
    last = -1;
    grants = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      chg = bus.ack_tgl ^ prev_ack;
      if (chg != '0) begin
        g = chg[1] ? 1 : 0;
        checks++;
        if (chg == 2'b11 || g == last) begin
          errors++;
          $display("FAIL fair_alternate: cycle %0d changed=%b last=%0d, want one grant to other ch",
                   cyc, chg, last);
        end
        $display("grant ch=%0d", g);
        last = g;
        grants++;
      end
      prev_ack = bus.ack_tgl;
      for (int c = 0; c < NCH; c++)
        if (bus.req_tgl[c] == bus.ack_tgl[c]) send(c, 8'($urandom_range(0, 255)));
      @(negedge clk);
    end
    checks++;
    if (grants < 15) begin
      errors++;
      $display("FAIL fair_count: grants=%0d want >= 15", grants);
    end
    drained = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req_tgl == bus.ack_tgl && bus.out_valid == 1'b0) begin
        drained = 1'b1;
        break;
      end
    end
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL fair_drain: ack=%b req=%b valid=%b want settled",
               bus.ack_tgl, bus.req_tgl, bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    int j;
    bit drain;
    do_reset();
    model_q.delete();
    for (int cyc = 0; cyc < 460; cyc++) begin
      drain = (cyc >= 400);
      bus.out_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
      checks++;
      if (bus.level > 3'(DEPTH) || bus.out_valid !== (bus.level != 3'd0)) begin
        errors++;
        $display("FAIL rand_level: level=%0d valid=%b want <=4 and valid==(level!=0)",
                 bus.level, bus.out_valid);
      end
      if (bus.out_valid && bus.out_ready) begin
        j = -1;
        for (int k = 0; k < model_q.size(); k++)
          if (j < 0 && model_q[k].ch == int'(bus.out_ch)) j = k;
        checks++;
        if (j < 0) begin
          errors++;
          $display("FAIL rand_pop: ch=%0d data=%h, want no entry (none sent)", bus.out_ch, bus.out_data);
        end else begin
          if (bus.out_data !== model_q[j].data) begin
            errors++;
            $display("FAIL rand_pop: ch=%0d data=%h want %h", bus.out_ch, bus.out_data, model_q[j].data);
          end
          model_q.delete(j);
        end
        $display("pop ch=%0d data=%02h", bus.out_ch, bus.out_data);
      end
      if (!drain) begin
        for (int c = 0; c < NCH; c++) begin
          if (bus.req_tgl[c] == bus.ack_tgl[c] && $urandom_range(0, 3) == 0) begin
            entry_t e;
            e.ch = c;
            e.data = 8'($urandom_range(0, 255));
            send(c, e.data);
            model_q.push_back(e);
          end
        end
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    checks++;
    if (model_q.size() != 0 || bus.out_valid !== 1'b0 || bus.req_tgl !== bus.ack_tgl) begin
      errors++;
      $display("FAIL rand_final: outstanding=%0d valid=%b req=%b ack=%b want 0/0/req==ack",
               model_q.size(), bus.out_valid, bus.req_tgl, bus.ack_tgl);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] nd;
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(i % 2, 8'($urandom_range(0, 255)));
      wait_ack(i % 2, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rmid_ack%0d: ack timeout, want ack within 20 cycles", i);
      end
    end
    checks++;
    if (bus.level !== 3'd3 || bus.req_tgl[1] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_setup: level=%0d req1=%b want 3/1", bus.level, bus.req_tgl[1]);
    end
    nd = 8'($urandom_range(0, 255));
    bus.data_in[DW +: DW] = nd;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.level !== 3'd0 || bus.ack_tgl !== 2'b00) begin
      errors++;
      $display("FAIL rmid_async: valid=%b level=%0d ack=%b want 0/0/00",
               bus.out_valid, bus.level, bus.ack_tgl);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.pending[1] !== 1'b1) begin
      errors++;
      $display("FAIL rmid_e2: valid=%b pend1=%b want 0/1", bus.out_valid, bus.pending[1]);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 1'b1 || bus.out_data !== nd ||
        bus.level !== 3'd1 || bus.ack_tgl !== 2'b10) begin
      errors++;
      $display("FAIL rmid_e3: valid=%b ch=%0d data=%h level=%0d ack=%b want 1/1/%h/1/10",
               bus.out_valid, bus.out_ch, bus.out_data, bus.level, bus.ack_tgl, nd);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_back_pressure();
    test_fairness();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
